// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// A request transfers when imem_req & imem_ready; responses return in order on imem_rvalid.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the fetch PC, keeps at most one request outstanding
// to instruction memory, buffers returned words in a 2-entry queue for decode, and
// redirects on a taken branch while discarding any wrong-path response.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   Br_taken,
    input  logic [31:0]            Br_addr,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            Instruction,
    output logic [31:0]            PC,
    output logic                   valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // free to issue a request
        WAIT  = 2'd1,   // one request outstanding, its word will be kept
        DROP  = 2'd2    // one request outstanding, its word is wrong-path
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];

    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_count_next;
    logic        w_req;
    logic        w_accept;
    logic [31:0] w_br_target;
    logic        w_unused_br_lo;

    // Branch targets are word aligned; the two low bits carry no information.
    assign w_br_target    = {Br_addr[31:2], 2'b00};
    assign w_unused_br_lo = ^Br_addr[1:0];

    assign w_valid = (r_count != 2'd0);
    // A taken branch flushes the queue, so nothing is popped or pushed that cycle.
    assign w_pop   = w_valid & ~freeze & ~Br_taken;
    assign w_push  = (r_state == WAIT) & imem.imem_rvalid & ~Br_taken;

    // Never underflows: pop requires a non-empty queue.
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // A new request may ride on the cycle the outstanding response returns, but only
    // when the queue will still have room for the word it brings back.
    assign w_req = ~rst
                 & ((r_state == FETCH) | ((r_state == WAIT) & imem.imem_rvalid & ~Br_taken))
                 & (w_count_next < 2'd2);
    assign w_accept = w_req & imem.imem_ready;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fetch_pc;

    assign valid       = w_valid;
    assign Instruction = w_valid ? r_q_instr[0] : 32'h0;
    assign PC          = w_valid ? r_q_pc[0]    : 32'h0;

    // Control FSM: state, fetch PC and queue occupancy, with branch taking priority.
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
        end else if (Br_taken) begin
            r_fetch_pc <= w_br_target;
            r_count    <= 2'd0;
            case (r_state)
                FETCH:   r_state <= w_accept ? DROP : FETCH;
                // A response arriving with the branch is the wrong-path word itself.
                WAIT:    r_state <= imem.imem_rvalid ? FETCH : DROP;
                DROP:    r_state <= imem.imem_rvalid ? FETCH : DROP;
                default: r_state <= FETCH;
            endcase
        end else begin
            r_count <= w_count_next;
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            case (r_state)
                FETCH:   r_state <= w_accept ? WAIT : FETCH;
                WAIT:    if (imem.imem_rvalid) r_state <= w_accept ? WAIT : FETCH;
                DROP:    if (imem.imem_rvalid) r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Queue storage: head in entry 0, shifts forward on pop. While in WAIT the fetch
    // PC has already advanced past the outstanding request, so it equals that
    // request's tag (address + 4).
    // NOTE: the data entries carry no reset; occupancy is tracked by r_count and the
    // outputs are gated by it, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_push && w_pop) begin
            if (r_count == 2'd2) begin
                r_q_pc[0]    <= r_q_pc[1];
                r_q_instr[0] <= r_q_instr[1];
                r_q_pc[1]    <= r_fetch_pc;
                r_q_instr[1] <= imem.imem_rdata;
            end else begin
                r_q_pc[0]    <= r_fetch_pc;
                r_q_instr[0] <= imem.imem_rdata;
            end
        end else if (w_push) begin
            // Push without pop only happens with 0 or 1 entries occupied.
            r_q_pc[r_count[0]]    <= r_fetch_pc;
            r_q_instr[r_count[0]] <= imem.imem_rdata;
        end else if (w_pop) begin
            r_q_pc[0]    <= r_q_pc[1];
            r_q_instr[0] <= r_q_instr[1];
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage. The memory model returns the request
// address as data after a programmable latency.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        valid;

    int checks;
    int errors;

    // Memory model controls
    int          mem_lat;
    logic        mem_ready;
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_paddr;

    if_fetch_stage_if imem ();

    if_fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .Br_taken    (Br_taken),
        .Br_addr     (Br_addr),
        .imem        (imem),
        .Instruction (Instruction),
        .PC          (PC),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem.imem_ready = mem_ready;

    // In-order memory, one outstanding request, data = address.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem.imem_rvalid <= 1'b0;
            imem.imem_rdata  <= 32'h0;
            m_pend           <= 1'b0;
            m_cnt            <= 0;
            m_paddr          <= 32'h0;
        end else begin
            imem.imem_rvalid <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 1) begin
                    imem.imem_rvalid <= 1'b1;
                    imem.imem_rdata  <= m_paddr;
                    m_pend           <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem.imem_req && imem.imem_ready) begin
                if (mem_lat == 1) begin
                    imem.imem_rvalid <= 1'b1;
                    imem.imem_rdata  <= imem.imem_addr;
                end else begin
                    m_pend  <= 1'b1;
                    m_paddr <= imem.imem_addr;
                    m_cnt   <= mem_lat - 1;
                end
            end
        end
    end

    // Leaves the bench at the sampling point of cycle 0 (first cycle out of reset).
    task automatic do_reset(input int lat);
        @(negedge clk);
        rst       = 1'b1;
        freeze    = 1'b0;
        Br_taken  = 1'b0;
        Br_addr   = 32'h0;
        mem_ready = 1'b1;
        mem_lat   = lat;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({valid, imem.imem_req, PC, Instruction} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b req=%b PC=%h I=%h, want all 0",
                     valid, imem.imem_req, PC, Instruction);
        end
    endtask

    task automatic test_stream();
        do_reset(1);
        checks++;
        if ({imem.imem_req, imem.imem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL stream_first_req: got req=%b addr=%h valid=%b, want 1/0/0",
                     imem.imem_req, imem.imem_addr, valid);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'(4 * k)}) begin
                errors++;
                $display("FAIL stream_req c%0d: got req=%b addr=%h, want 1/%h",
                         k, imem.imem_req, imem.imem_addr, 32'(4 * k));
            end
            if (k == 1) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_valid_early c1: got %b want 0", valid);
                end
            end else begin
                checks++;
                if ({valid, PC, Instruction} !== {1'b1, 32'(4 * k - 4), 32'(4 * k - 8)}) begin
                    errors++;
                    $display("FAIL stream_head c%0d: got %b/%h/%h want 1/%h/%h", k,
                             valid, PC, Instruction, 32'(4 * k - 4), 32'(4 * k - 8));
                end
            end
        end
    endtask

    task automatic test_freeze();
        do_reset(1);
        repeat (4) @(negedge clk);
        // Cycles 5..9 frozen: head {PC=16, I=12} held, queue fills, requests stop.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            freeze = 1'b1;
            #1;
            checks++;
            if ({valid, PC, Instruction, imem.imem_req} !== {1'b1, 32'd16, 32'd12, 1'b0}) begin
                errors++;
                $display("FAIL freeze_hold f%0d: got %b/%h/%h req=%b want 1/10/0c req=0",
                         i, valid, PC, Instruction, imem.imem_req);
            end
        end
        @(negedge clk);
        freeze = 1'b0;
        #1;
        checks++;
        if ({PC, Instruction, imem.imem_req, imem.imem_addr} !== {32'd16, 32'd12, 1'b1, 32'd20}) begin
            errors++;
            $display("FAIL freeze_release: got %h/%h req=%b addr=%h want 10/0c 1/14",
                     PC, Instruction, imem.imem_req, imem.imem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({valid, PC, Instruction} !== {1'b1, 32'(20 + 4 * k), 32'(16 + 4 * k)}) begin
                errors++;
                $display("FAIL freeze_resume r%0d: got %b/%h/%h want 1/%h/%h", k,
                         valid, PC, Instruction, 32'(20 + 4 * k), 32'(16 + 4 * k));
            end
        end
    endtask

    task automatic test_branch_wait();
        do_reset(3);
        @(negedge clk);
        // Cycle 1: WAIT with response pending; branch to 0x100.
        Br_taken = 1'b1;
        Br_addr  = 32'h100;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL brw_req_in_wait: got %b want 0", imem.imem_req);
        end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            Br_taken = 1'b0;
            #1;
            checks++;
            if ({valid, imem.imem_req} !== 2'b00) begin
                errors++;
                $display("FAIL brw_drop c%0d: got valid=%b req=%b want 0/0", c, valid, imem.imem_req);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL brw_target_req: got valid=%b req=%b addr=%h want 0/1/100",
                     valid, imem.imem_req, imem.imem_addr);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({valid, PC, Instruction} !== {1'b1, 32'h104, 32'h100}) begin
            errors++;
            $display("FAIL brw_first_target: got %b/%h/%h want 1/104/100", valid, PC, Instruction);
        end
    endtask

    task automatic test_branch_rvalid();
        do_reset(1);
        repeat (3) @(negedge clk);
        // Cycle 3: response for addr 8 arrives with the branch; low bits of target ignored.
        Br_taken = 1'b1;
        Br_addr  = 32'h203;
        #1;
        checks++;
        if (imem.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL brr_no_req: got %b want 0", imem.imem_req);
        end
        @(negedge clk);
        Br_taken = 1'b0;
        #1;
        checks++;
        if ({valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL brr_flush: got valid=%b req=%b addr=%h want 0/1/200",
                     valid, imem.imem_req, imem.imem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL brr_stale_push: got valid=%b PC=%h want valid 0", valid, PC);
        end
        @(negedge clk); #1;
        checks++;
        if ({valid, PC, Instruction} !== {1'b1, 32'h204, 32'h200}) begin
            errors++;
            $display("FAIL brr_first_target: got %b/%h/%h want 1/204/200", valid, PC, Instruction);
        end
    endtask

    task automatic test_ready_low();
        do_reset(1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            mem_ready = 1'b0;
            #1;
            checks++;
            if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL ready_stall c%0d: got req=%b addr=%h want 1/0",
                         c, imem.imem_req, imem.imem_addr);
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL ready_accept: got req=%b addr=%h want 1/0", imem.imem_req, imem.imem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (imem.imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL ready_advance: got addr=%h want 4", imem.imem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if ({valid, PC, Instruction} !== {1'b1, 32'h4, 32'h0}) begin
            errors++;
            $display("FAIL ready_first_word: got %b/%h/%h want 1/4/0", valid, PC, Instruction);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        repeat (5) @(negedge clk);
        freeze = 1'b1;
        #1;
        checks++;
        if ({valid, imem.imem_rvalid} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_precond: got valid=%b rvalid=%b want 1/1", valid, imem.imem_rvalid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, imem.imem_req, PC, Instruction} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_immediate: got valid=%b req=%b PC=%h I=%h want all 0",
                     valid, imem.imem_req, PC, Instruction);
        end
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        freeze = 1'b0;
        #1;
        checks++;
        if ({imem.imem_req, imem.imem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_restart: got req=%b addr=%h valid=%b want 1/0/0",
                     imem.imem_req, imem.imem_addr, valid);
        end
        @(negedge clk); #1;
        checks++;
        if ({imem.imem_req, imem.imem_addr, valid} !== {1'b1, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_second: got req=%b addr=%h valid=%b want 1/4/0",
                     imem.imem_req, imem.imem_addr, valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        freeze    = 1'b0;
        Br_taken  = 1'b0;
        Br_addr   = 32'h0;
        mem_ready = 1'b1;
        mem_lat   = 1;
        test_reset();
        test_stream();
        test_freeze();
        test_branch_wait();
        test_branch_rvalid();
        test_ready_low();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
